// File: rtl/vga_plot_sink_if.sv
// Pixel-plot bus between the fractal renderer (master) and the plot sink (slave).
interface vga_plot_sink_if;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       clear_req;
    logic       clear_busy;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, clear_req,
        input  clear_busy
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, clear_req,
        output clear_busy
    );
endinterface

// File: rtl/vga_plot_sink.sv
// 320x240x3 framebuffer fed by the plot bus, scanned out pixel-doubled as 640x480@60 VGA,
// with a sequential clear engine that also runs out of reset.
module vga_plot_sink #(
    parameter int unsigned CLK_DIV      = 2,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic           clk,
    input  logic           rstn,
    vga_plot_sink_if.slave plot,
    output logic [2:0]     vga_rgb,
    output logic           vga_hs,
    output logic           vga_vs,
    output logic           vga_de
);

    localparam int unsigned FB_W     = 320;
    localparam int unsigned FB_H     = 240;
    localparam int unsigned FB_WORDS = FB_W * FB_H;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned H_VIS    = 640;
    localparam int unsigned HS_START = 656;
    localparam int unsigned HS_END   = 751;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned V_VIS    = 480;
    localparam int unsigned VS_START = 490;
    localparam int unsigned VS_END   = 491;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    // y*320 + x built from shifts so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] y, input logic [8:0] x);
        return ADDR_W'({y, 8'd0}) + ADDR_W'({y, 6'd0}) + ADDR_W'(x);
    endfunction

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q;
    logic              clr_we_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= (state_d == CLEAR);
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (plot.clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_we_c   = 1'b1;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(FB_WORDS - 1)) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                clr_addr_d = '0;
            end
        endcase
    end

    assign plot.clear_busy = busy_q;

    // ------------------------------------------------------------------
    // Write port arbitration: the clear engine always wins over plots
    // ------------------------------------------------------------------
    logic              plot_we_c;
    logic              fb_we_c;
    logic [ADDR_W-1:0] fb_waddr_c;
    logic [2:0]        fb_wdata_c;

    always_comb begin
        plot_we_c = plot.vga_plot && (state_q == IDLE) && !plot.clear_req &&
                    (plot.vga_x < 9'(FB_W)) && (plot.vga_y < 8'(FB_H));
        fb_we_c    = clr_we_c || plot_we_c;
        fb_waddr_c = clr_we_c ? clr_addr_q : fb_addr(plot.vga_y, plot.vga_x);
        fb_wdata_c = clr_we_c ? CLEAR_COLOUR : plot.vga_colour;
    end

    // ------------------------------------------------------------------
    // Timing generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] h_q, v_q;
    logic             pe_c;

    assign pe_c = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else if (pe_c) begin
            div_q <= '0;
            if (h_q == CNT_W'(H_TOTAL - 1)) begin
                h_q <= '0;
                v_q <= (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_q <= h_q + CNT_W'(1);
            end
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    logic              vis_c, hs_c, vs_c;
    logic [ADDR_W-1:0] scan_addr_c;

    // Blanking lines would index past the framebuffer, so the scan address parks at 0 there.
    always_comb begin
        vis_c       = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
        hs_c        = !((h_q >= CNT_W'(HS_START)) && (h_q <= CNT_W'(HS_END)));
        vs_c        = !((v_q >= CNT_W'(VS_START)) && (v_q <= CNT_W'(VS_END)));
        scan_addr_c = vis_c ? fb_addr(v_q[8:1], h_q[9:1]) : '0;
    end

    // ------------------------------------------------------------------
    // Framebuffer: simple dual-port, registered read every clk
    // ------------------------------------------------------------------
    logic [2:0] mem [FB_WORDS];
    logic [2:0] rdata_q;

    always_ff @(posedge clk) begin
        if (fb_we_c) begin
            mem[fb_waddr_c] <= fb_wdata_c;
        end
        rdata_q <= mem[scan_addr_c];
    end

    // ------------------------------------------------------------------
    // Output stage: all four outputs move together on pe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vga_rgb <= '0;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_de  <= 1'b0;
        end else if (pe_c) begin
            vga_rgb <= vis_c ? rdata_q : 3'b000;
            vga_hs  <= hs_c;
            vga_vs  <= vs_c;
            vga_de  <= vis_c;
        end
    end

endmodule
